// File: rtl/ddr3_rw_scheduler.sv
// ddr3_rw_scheduler
//
// Picks between the user write and read request queues and offers one burst
// command at a time to the data path. It keeps the data bus occupied for
// BURST_CYCLES after each accepted command. It inserts read/write turnaround
// gaps when the direction changes. It limits how many commands one direction
// may issue while the other direction is waiting.
//
// Ports
//   clk           controller clock
//   reset         synchronous, active-high reset
//   wr_req_valid  write request pending        wr_req_addr  write address
//   wr_req_ready  write request accepted (handshake cycle only)
//   wr_urgent     write FIFO near full; writes win arbitration
//   rd_req_valid  read request pending         rd_req_addr  read address
//   rd_req_ready  read request accepted (handshake cycle only)
//   cmd_valid     command offered to data path
//   cmd_write     offered command is a write   cmd_read  offered command is a read
//   cmd_addr      offered command address      cmd_ready data path accepts command
//   busy          scheduler not idle
//   cur_dir       direction of last or current command (1 = write)
//
// State   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no command in flight; arbitrate every cycle
// TURN    | direction committed; waiting for the turnaround gap to elapse
// ISSUE   | command offered; held until cmd_ready
// BURST   | data bus occupied; arbitrate on the last burst cycle
module ddr3_rw_scheduler #(
    parameter int ADDR_WIDTH   = 28,
    parameter int BURST_CYCLES = 4,
    parameter int WR_TO_RD_GAP = 6,
    parameter int RD_TO_WR_GAP = 4,
    parameter int BATCH_MAX    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req_valid,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    output logic                  wr_req_ready,
    input  logic                  wr_urgent,
    input  logic                  rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_req_ready,
    output logic                  cmd_valid,
    output logic                  cmd_write,
    output logic                  cmd_read,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_ready,
    output logic                  busy,
    output logic                  cur_dir
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        ISSUE = 2'd2,
        BURST = 2'd3
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST_CYCLES - 1);
    localparam logic [3:0] GAP_W2R    = 4'(WR_TO_RD_GAP);
    localparam logic [3:0] GAP_R2W    = 4'(RD_TO_WR_GAP);
    localparam logic [3:0] BATCH_LIM  = 4'(BATCH_MAX);

    state_t     state_q, state_d;
    logic       cur_dir_q, cur_dir_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] batch_q, batch_d;
    logic [3:0] burst_q, burst_d;

    logic       pick_dir;
    logic       sel_run;
    logic       issue_act;

    // Arbitration result; only consumed when at least one request is valid.
    always_comb begin
        pick_dir = cur_dir_q;
        if (wr_req_valid && !rd_req_valid) begin
            pick_dir = 1'b1;
        end else if (rd_req_valid && !wr_req_valid) begin
            pick_dir = 1'b0;
        end else if (wr_urgent) begin
            pick_dir = 1'b1;
        end else if (batch_q < BATCH_LIM) begin
            pick_dir = cur_dir_q;
        end else begin
            pick_dir = !cur_dir_q;
        end
    end

    // The turnaround decision looks at gap_d, the value gap_cnt holds in the
    // next cycle. A command therefore enters ISSUE in the first cycle that
    // the gap has fully elapsed, so exactly WR_TO_RD_GAP / RD_TO_WR_GAP idle
    // clocks separate a burst from an opposite-direction command.
    always_comb begin
        state_d   = state_q;
        cur_dir_d = cur_dir_q;
        batch_d   = batch_q;
        burst_d   = burst_q;
        gap_d     = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
        sel_run   = 1'b0;

        case (state_q)
            IDLE: begin
                sel_run = 1'b1;
            end
            TURN: begin
                if (gap_d == 4'd0) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = BURST;
                    burst_d = BURST_LAST;
                end
            end
            BURST: begin
                if (burst_q == 4'd0) begin
                    gap_d   = cur_dir_q ? GAP_W2R : GAP_R2W;
                    sel_run = 1'b1;
                end else begin
                    burst_d = burst_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (sel_run) begin
            if (!wr_req_valid && !rd_req_valid) begin
                state_d = IDLE;
            end else if (pick_dir == cur_dir_q) begin
                state_d = ISSUE;
                batch_d = (batch_q >= BATCH_LIM) ? BATCH_LIM : batch_q + 4'd1;
            end else begin
                cur_dir_d = pick_dir;
                batch_d   = 4'd1;
                state_d   = (gap_d == 4'd0) ? ISSUE : TURN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_dir_q <= 1'b0;
            gap_q     <= 4'd0;
            batch_q   <= 4'd0;
            burst_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            cur_dir_q <= cur_dir_d;
            gap_q     <= gap_d;
            batch_q   <= batch_d;
            burst_q   <= burst_d;
        end
    end

    // Outputs are forced low while reset is high so that a handshake pending
    // in the reset cycle is abandoned rather than half-completed.
    assign issue_act    = !reset && (state_q == ISSUE);
    assign cmd_valid    = issue_act;
    assign cmd_write    = issue_act && cur_dir_q;
    assign cmd_read     = issue_act && !cur_dir_q;
    assign cmd_addr     = issue_act ? (cur_dir_q ? wr_req_addr : rd_req_addr)
                                    : '0;
    assign wr_req_ready = cmd_write && cmd_ready;
    assign rd_req_ready = cmd_read && cmd_ready;
    assign busy         = !reset && (state_q != IDLE);
    assign cur_dir      = !reset && cur_dir_q;

endmodule

// File: doc/ddr3_rw_scheduler.md
Name: ddr3_rw_scheduler

Overview:
- Arbitrates between a user write-request queue and a user read-request queue.
- Issues one burst command at a time (cmd_write/cmd_read/cmd_valid) to the data path.
- Enforces burst occupancy, read/write bus-turnaround gaps and per-direction batching limits.
- Sits between the user command front-end and data_path. It is the only source of cmd_* for data_path.

Parameters:
- ADDR_WIDTH, 28, width of request and command address.
- BURST_CYCLES, 4, controller clocks one BL8 burst occupies the data bus (range 1..15).
- WR_TO_RD_GAP, 6, idle clocks required after a write burst before a read command (range 0..15).
- RD_TO_WR_GAP, 4, idle clocks required after a read burst before a write command (range 0..15).
- BATCH_MAX, 4, commands in one direction before yielding to a waiting opposite direction (range 1..15).

Ports:
- clk  in  1  controller clock.
- reset  in  1  synchronous, active-high reset.
- wr_req_valid  in  1  write request pending.
- wr_req_addr  in  ADDR_WIDTH  write address.
- wr_req_ready  out  1  write request accepted this cycle.
- wr_urgent  in  1  write FIFO near full; gives writes priority.
- rd_req_valid  in  1  read request pending.
- rd_req_addr  in  ADDR_WIDTH  read address.
- rd_req_ready  out  1  read request accepted this cycle.
- cmd_valid  out  1  command offered to data path.
- cmd_write  out  1  offered command is a write.
- cmd_read  out  1  offered command is a read.
- cmd_addr  out  ADDR_WIDTH  offered command address.
- cmd_ready  in  1  data path accepts command.
- busy  out  1  state != IDLE.
- cur_dir  out  1  direction of last or current command (1 = write).

Behaviour:

Clock and reset:
- One clock domain: clk.
- reset is synchronous and active-high.
- On reset: state=IDLE, cur_dir=0, gap_cnt=0, batch_cnt=0, burst_cnt=0.
- On reset all outputs are 0; cmd_addr=0.
- Reset asserted in any state abandons the burst and any pending handshake; nothing is issued on the following cycle.

States: IDLE, TURN, ISSUE, BURST.

Direction selection (evaluated in IDLE, and at the last BURST cycle):
- Candidates are wr_req_valid and rd_req_valid.
- If only one is valid, that direction is chosen.
- If both are valid:
  - wr_urgent=1 selects write.
  - Otherwise continue cur_dir if batch_cnt<BATCH_MAX.
  - Otherwise switch direction.
  - From IDLE with batch_cnt=0 and wr_urgent=0, read wins.
- Chosen dir == cur_dir: go to ISSUE and increment batch_cnt, saturating at BATCH_MAX.
- Chosen dir != cur_dir:
  - cur_dir <= chosen dir, batch_cnt <= 1.
  - If gap_cnt==0 go to ISSUE, else go to TURN.
- No candidate: go to IDLE.

TURN:
- Wait until gap_cnt==0, then go to ISSUE.
- Requests are not re-evaluated in TURN; the direction is committed.

ISSUE:
- cmd_valid=1; cmd_write=cur_dir; cmd_read=!cur_dir.
- cmd_addr is muxed combinationally from the selected request's addr.
- Handshake occurs in the cycle where cmd_valid&cmd_ready.
- In the handshake cycle the matching wr_req_ready/rd_req_ready=1 (combinational), for that cycle only.
- Next state is BURST with burst_cnt=BURST_CYCLES-1.
- cmd_ready low holds ISSUE indefinitely with cmd fields stable. There is no timeout.
- Requesters hold valid/addr until ready. A drop of valid in ISSUE is a protocol violation; its behaviour is undefined.

BURST:
- burst_cnt decrements each cycle.
- When burst_cnt==0: gap_cnt <= (cur_dir ? WR_TO_RD_GAP : RD_TO_WR_GAP), and direction selection runs.
- Back-to-back same-direction commands are therefore spaced exactly BURST_CYCLES+1 cycles apart, handshake to handshake, with cmd_ready=1.

gap_cnt:
- 4-bit; decrements every cycle when nonzero, in all states including IDLE.
- Only the load in BURST overrides the decrement.

Latency:
- Request valid sampled in IDLE at edge k gives cmd_valid high in cycle k+1, when no gap applies.

Mutual exclusion:
- cmd_read and cmd_write are never both 1.
- cmd_valid=0 implies cmd_read=cmd_write=0.
- wr_req_ready and rd_req_ready are never both 1.

Test Plan:
- Reset, then rd_req_valid=1 at addr 0x100, cmd_ready=1: cmd_valid/cmd_read high on the 2nd cycle with cmd_addr=0x100, rd_req_ready pulses once, busy=1 for BURST_CYCLES+1 cycles, then IDLE.
- 6 queued reads (defaults): handshakes every 5 cycles; cur_dir stays 0; no gap inserted.
- Both valid continuously, wr_urgent=0: 4 reads, then TURN of RD_TO_WR_GAP=4 cycles, then 4 writes, then a 6-cycle gap, then reads; sequence R×4,W×4,R×4.
- Read pending during write batch with wr_urgent=1: writes continue past BATCH_MAX; the read is issued only after wr_urgent drops and the write batch completes.
- cmd_ready held low 10 cycles in ISSUE: cmd_valid/cmd_addr stable, no req_ready pulse; ready asserted on cycle 11 gives exactly one handshake.
- reset pulsed mid-BURST and mid-TURN: next cycle all outputs 0, state IDLE, gap_cnt cleared, so the next request issues with no turnaround gap.
